// File: rtl/rr_arb_4_grant.sv
// rr_arb_4_grant: 4-requester round-robin arbiter with a registered grant index.
// The grant is held until the owner drops its request or en falls.
// Optional hold-timeout revoke is built when ARB_TIMEOUT_EN is defined.
module rr_arb_4_grant #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       busy,
  output logic       to_pulse
);

  // The hold counter must be able to reach HOLD_MAX-1.
  if ((64'd1 << CNT_W) <= 64'(HOLD_MAX)) begin : g_cnt_w_check
    $error("rr_arb_4_grant: CNT_W too narrow for HOLD_MAX");
  end

  // Two-bit encoding so that stray values can be decoded back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx_nxt;
  logic [1:0] ptr;
  logic [1:0] ptr_nxt;
  logic [1:0] win;
  logic       win_vld;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             to_nxt;
`endif

  // Round-robin search: first requester at or after ptr, wrapping mod 4.
  always_comb begin
    logic [1:0] cand;
    cand    = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, hold or release in GRANT.
  always_comb begin
    state_nxt = state;
    idx_nxt   = gnt_idx;
    ptr_nxt   = ptr;
`ifdef ARB_TIMEOUT_EN
    cnt_nxt   = '0;
    to_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (en && win_vld) begin
          state_nxt = GRANT;
          idx_nxt   = win;
          ptr_nxt   = win + 2'd1;
        end
      end
      GRANT: begin
        if (!en || !req[gnt_idx]) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(HOLD_MAX - 1)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // State, index and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      gnt_idx <= idx_nxt;
      ptr     <= ptr_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and one-cycle revoke pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      to_pulse <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      to_pulse <= to_nxt;
    end
  end
`else
  assign to_pulse = 1'b0;
`endif

  // Outputs decoded purely from registered state and index.
  always_comb begin
    gnt_vld = (state == GRANT);
    busy    = gnt_vld;
    gnt     = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule
